// File: rtl/ifid_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_queue_pkg
// Description : Shared pipeline definitions for the IF/ID instruction queue:
//               word width, the NOP encoding that is presented when the queue
//               is empty, the occupancy state encoding and the packed entry.
// Revision    : 1.0 - initial release
// ============================================================================
package ifid_queue_pkg;

    localparam int WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] NOP_INSTRUCTION = 32'h00000000;
    localparam int ENTRY_WIDTH = 2 * WORD_WIDTH;

    // Occupancy of the queue; derived from the entry count.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_state_e;

    // One queued fetch result. PC+4 sits in the upper half of the stored word.
    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc_more4;
        logic [WORD_WIDTH-1:0] instruction;
    } ifid_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifid_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : ifid_queue_if
// Description : Handshake bundle between fetch, the IF/ID queue and decode.
//               slave  - the queue itself
//               master - the environment (fetch + decode + redirect logic)
//               Signals: flush, inValid/inReady/inInstruction/inPcMore4,
//               pcStall, outValid/outReady/outInstruction/outPcMore4, count.
// Revision    : 1.0 - initial release
// ============================================================================
interface ifid_queue_if #(
    parameter int DEPTH = 2
) ();
    import ifid_queue_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  flush;
    logic                  inValid;
    logic [WORD_WIDTH-1:0] inInstruction;
    logic [WORD_WIDTH-1:0] inPcMore4;
    logic                  inReady;
    logic                  pcStall;
    logic                  outValid;
    logic                  outReady;
    logic [WORD_WIDTH-1:0] outInstruction;
    logic [WORD_WIDTH-1:0] outPcMore4;
    logic [CNT_W-1:0]      count;

    modport slave (
        input  flush, inValid, inInstruction, inPcMore4, outReady,
        output inReady, pcStall, outValid, outInstruction, outPcMore4, count
    );

    modport master (
        output flush, inValid, inInstruction, inPcMore4, outReady,
        input  inReady, pcStall, outValid, outInstruction, outPcMore4, count
    );

endinterface
`default_nettype wire

// File: rtl/ifid_queue_storage.sv
`default_nettype none
// ============================================================================
// Module      : ifid_queue_storage
// Description : DEPTH x 64-bit register array, one synchronous write port and
//               one asynchronous read port. Contents are not reset; the parent
//               masks the read data whenever the queue is empty.
//   clk        - clock
//   wr_en_i    - write strobe
//   wr_addr_i  - write address
//   wr_data_i  - write data
//   rd_addr_i  - read address
//   rd_data_o  - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_queue_storage
    import ifid_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic                   clk,
    input  wire logic                   wr_en_i,
    input  wire logic [PTR_W-1:0]       wr_addr_i,
    input  wire logic [ENTRY_WIDTH-1:0] wr_data_i,
    input  wire logic [PTR_W-1:0]       rd_addr_i,
    output      logic [ENTRY_WIDTH-1:0] rd_data_o
);

    logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/ifid_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifid_queue
// Description : IF/ID decoupling FIFO. Holds fetched instruction/PC+4 pairs
//               until decode consumes them. A flush (branch/jump redirect)
//               empties the queue and drops any same-cycle push.
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset
//   q          - handshake bundle (slave side), see ifid_queue_if
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_queue
    import ifid_queue_pkg::*;
#(
    parameter int DEPTH = 2   // power of two, >= 2
) (
    input  wire logic   clk,
    input  wire logic   reset,
    ifid_queue_if.slave q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] C_FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q,  count_d;
    occ_state_e             occ_w;
    logic                   push_w;
    logic                   pop_w;
    logic [ENTRY_WIDTH-1:0] rd_data_w;
    ifid_entry_t            head_w;
    ifid_entry_t            wr_entry_w;

    // Occupancy state follows directly from the registered count, so the
    // handshake outputs carry no combinational path from the in* inputs.
    always_comb begin
        if (count_q == '0) begin
            occ_w = EMPTY;
        end else if (count_q == C_FULL_COUNT) begin
            occ_w = FULL;
        end else begin
            occ_w = PARTIAL;
        end
    end

    assign q.inReady  = (occ_w != FULL);
    assign q.pcStall  = ~q.inReady;
    assign q.outValid = (occ_w != EMPTY);
    assign q.count    = count_q;

    assign push_w = q.inValid  && q.inReady  && !q.flush;
    assign pop_w  = q.outValid && q.outReady && !q.flush;

    // DEPTH is a power of two, so pointer wrap is the natural PTR_W overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_w) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_w) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_w && !pop_w) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_w && !push_w) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || q.flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_entry_w.instruction = q.inInstruction;
    assign wr_entry_w.pc_more4    = q.inPcMore4;

    ifid_queue_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk       (clk),
        .wr_en_i   (push_w),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_entry_w),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data_w)
    );

    assign head_w = rd_data_w;

    // Stale storage is never visible: an empty queue presents a NOP.
    assign q.outInstruction = q.outValid ? head_w.instruction : NOP_INSTRUCTION;
    assign q.outPcMore4     = q.outValid ? head_w.pc_more4    : '0;

endmodule
`default_nettype wire
